// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types.
// access_t : access type carried with every check request.
package rv_iopmp_pkg;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'b00,
        ACC_READ  = 2'b01,
        ACC_WRITE = 2'b10,
        ACC_EXEC  = 2'b11
    } access_t;

endpackage

// File: rtl/rv_iopmp_check_arbiter_if.sv
// Bundle of requester, response and check-engine signals around
// rv_iopmp_check_arbiter.
//   req_*  : per-requester request channel (valid/ready, payload)
//   rsp_*  : per-requester verdict pulse and shared allow bit
//   chk_*  : request to / status and verdict from the check engine
//   busy_o, timeout_o : status
// Modports: slave = arbiter view, master = environment view.
interface rv_iopmp_check_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int SID_WIDTH  = 8
) ();
    localparam int NBW = $clog2(DATA_WIDTH / 8) + 1;

    logic [NUM_REQ-1:0]                  req_valid_i;
    logic [NUM_REQ-1:0]                  req_ready_o;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr_i;
    logic [NUM_REQ-1:0][NBW-1:0]         req_num_bytes_i;
    logic [NUM_REQ-1:0][SID_WIDTH-1:0]   req_sid_i;
    rv_iopmp_pkg::access_t [NUM_REQ-1:0] req_access_i;

    logic [NUM_REQ-1:0]                  rsp_valid_o;
    logic                                rsp_allow_o;

    logic                                chk_en_o;
    logic [ADDR_WIDTH-1:0]               chk_addr_o;
    logic [NBW-1:0]                      chk_num_bytes_o;
    logic [SID_WIDTH-1:0]                chk_sid_o;
    rv_iopmp_pkg::access_t               chk_access_o;
    logic                                chk_ready_i;
    logic                                chk_valid_i;
    logic                                chk_allow_i;

    logic                                busy_o;
    logic                                timeout_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_num_bytes_i, req_sid_i, req_access_i,
        input  chk_ready_i, chk_valid_i, chk_allow_i,
        output req_ready_o, rsp_valid_o, rsp_allow_o,
        output chk_en_o, chk_addr_o, chk_num_bytes_o, chk_sid_o, chk_access_o,
        output busy_o, timeout_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_num_bytes_i, req_sid_i, req_access_i,
        output chk_ready_i, chk_valid_i, chk_allow_i,
        input  req_ready_o, rsp_valid_o, rsp_allow_o,
        input  chk_en_o, chk_addr_o, chk_num_bytes_o, chk_sid_o, chk_access_o,
        input  busy_o, timeout_o
    );

endinterface

// File: rtl/rv_iopmp_check_arbiter.sv
// Round-robin arbiter sharing one IOPMP check engine among NUM_REQ
// requesters, with a single check in flight.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : rv_iopmp_check_arbiter_if.slave (requests, responses,
//            check-engine channel, busy/timeout status)
// Optional feature: define RV_IOPMP_ARB_TIMEOUT_EN to enable a WAIT-state
// watchdog of TIMEOUT_CYCLES cycles; otherwise WAIT waits indefinitely
// and timeout_o is tied low.
module rv_iopmp_check_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int SID_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    rv_iopmp_check_arbiter_if.slave   bus
);
    import rv_iopmp_pkg::*;

    localparam int NBW   = $clog2(DATA_WIDTH / 8) + 1;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [IDX_W-1:0]      r_owner;
    logic                  r_verdict;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [NBW-1:0]        r_num_bytes;
    logic [SID_WIDTH-1:0]  r_sid;
    access_t               r_access;

    logic [IDX_W-1:0]      w_winner;
    logic [IDX_W-1:0]      w_cand;
    logic                  w_found;
    logic                  w_expire;
    logic                  w_chk_en;

    // Search starts at rr_ptr so the most recently served port is last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = IDX_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_found && bus.req_valid_i[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

`ifdef RV_IOPMP_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    // Counter is zero on the first WAIT cycle; expiry is the
    // TIMEOUT_CYCLES-th WAIT cycle, so RESP follows TIMEOUT_CYCLES
    // cycles after entering WAIT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt <= (r_state == S_WAIT) ? r_cnt + 1'b1 : '0;
            if (r_state == S_WAIT) begin
                // An engine verdict on the expiry cycle takes priority.
                r_timeout <= w_expire && !bus.chk_valid_i;
            end else if (r_state == S_RESP) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign w_expire      = (r_state == S_WAIT) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.timeout_o = (r_state == S_RESP) && r_timeout;
`else
    assign w_expire      = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
            S_ISSUE: if (bus.chk_ready_i) w_state_nxt = S_WAIT;
            S_WAIT:  if (bus.chk_valid_i || w_expire) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_verdict   <= 1'b0;
            r_addr      <= '0;
            r_num_bytes <= '0;
            r_sid       <= '0;
            r_access    <= ACC_NONE;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_found) begin
                r_owner     <= w_winner;
                r_addr      <= bus.req_addr_i[w_winner];
                r_num_bytes <= bus.req_num_bytes_i[w_winner];
                r_sid       <= bus.req_sid_i[w_winner];
                r_access    <= bus.req_access_i[w_winner];
            end
            if (r_state == S_WAIT) begin
                if (bus.chk_valid_i) begin
                    r_verdict <= bus.chk_allow_i;
                end else if (w_expire) begin
                    r_verdict <= 1'b0;
                end
            end
            if (r_state == S_RESP) begin
                r_rr_ptr <= (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
            end
        end
    end

    // Grant is combinational in IDLE; gated by reset so every output is
    // low while rst_ni is asserted even if requesters keep valid high.
    always_comb begin
        bus.req_ready_o = '0;
        bus.rsp_valid_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready_o[i] = rst_ni && (r_state == S_IDLE) && w_found
                                 && (w_winner == IDX_W'(i));
            bus.rsp_valid_o[i] = (r_state == S_RESP) && (r_owner == IDX_W'(i));
        end
    end

    assign w_chk_en            = (r_state == S_ISSUE) && bus.chk_ready_i;
    assign bus.chk_en_o        = w_chk_en;
    assign bus.chk_addr_o      = w_chk_en ? r_addr      : '0;
    assign bus.chk_num_bytes_o = w_chk_en ? r_num_bytes : '0;
    assign bus.chk_sid_o       = w_chk_en ? r_sid       : '0;
    assign bus.chk_access_o    = w_chk_en ? r_access    : ACC_NONE;
    assign bus.rsp_allow_o     = (r_state == S_RESP) && r_verdict;
    assign bus.busy_o          = (r_state != S_IDLE);

endmodule

// File: tb/tb_rv_iopmp_check_arbiter.sv
module tb_rv_iopmp_check_arbiter;
    import rv_iopmp_pkg::*;

    localparam int NUM_REQ        = 4;
    localparam int ADDR_WIDTH     = 64;
    localparam int DATA_WIDTH     = 64;
    localparam int SID_WIDTH      = 8;
    localparam int TIMEOUT_CYCLES = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rv_iopmp_check_arbiter_if #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .SID_WIDTH(SID_WIDTH)
    ) bus ();

    rv_iopmp_check_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .SID_WIDTH(SID_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] oh;
        logic       allow;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid_i     = '0;
        bus.req_addr_i      = '0;
        bus.req_num_bytes_i = '0;
        bus.req_sid_i       = '0;
        for (int i = 0; i < NUM_REQ; i++) bus.req_access_i[i] = ACC_NONE;
        bus.chk_ready_i     = 1'b0;
        bus.chk_valid_i     = 1'b0;
        bus.chk_allow_i     = 1'b0;
    endtask

    task automatic set_req(input int p, input logic [63:0] addr, input logic [7:0] sid,
                           input access_t acc);
        bus.req_valid_i[p]     = 1'b1;
        bus.req_addr_i[p]      = addr;
        bus.req_num_bytes_i[p] = 4'd8;
        bus.req_sid_i[p]       = sid;
        bus.req_access_i[p]    = acc;
    endtask

    task automatic push(input int p, input logic allow, input logic to);
        exp_t e;
        e.oh    = 4'b0001 << p;
        e.allow = allow;
        e.to    = to;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: compares every presented response with the
    // oldest expectation, plus per-cycle invariants.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rsp_valid_o != '0) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(bus.rsp_valid_o), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_owner", 64'(bus.rsp_valid_o), 64'(e.oh));
                    check("rsp_allow", 64'(bus.rsp_allow_o), 64'(e.allow));
                    check("rsp_timeout", 64'(bus.timeout_o), 64'(e.to));
                end
            end else begin
                check("timeout_without_rsp", 64'(bus.timeout_o), 64'd0);
            end
            if (bus.busy_o) check("ready_while_busy", 64'(bus.req_ready_o), 64'd0);
            if (!bus.chk_en_o)
                check("chk_payload_idle",
                      64'(|{bus.chk_addr_o, bus.chk_num_bytes_o, bus.chk_sid_o, bus.chk_access_o}),
                      64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        bus.req_valid_i = 4'b1111;
        #12;
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_ready", 64'(bus.req_ready_o), 64'd0);
        check("rst_chk_en", 64'(bus.chk_en_o), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("rst_timeout", 64'(bus.timeout_o), 64'd0);
        clear_inputs();
        tick();
        rst_n = 1'b1;

        // Lone requester 2, engine allows after 3 WAIT cycles.
        bus.chk_ready_i = 1'b1;
        set_req(2, 64'h0000_0000_8000_0000, 8'h05, ACC_READ);
        settle();
        check("t1_grant", 64'(bus.req_ready_o), 64'b0100);
        push(2, 1'b1, 1'b0);
        tick();
        bus.req_valid_i = '0;
        settle();
        check("t1_chk_en", 64'(bus.chk_en_o), 64'd1);
        check("t1_chk_addr", bus.chk_addr_o, 64'h8000_0000);
        check("t1_chk_sid", 64'(bus.chk_sid_o), 64'h05);
        check("t1_chk_bytes", 64'(bus.chk_num_bytes_o), 64'd8);
        tick();
        check("t1_chk_en_off", 64'(bus.chk_en_o), 64'd0);
        check("t1_busy", 64'(bus.busy_o), 64'd1);
        tick();
        tick();
        bus.chk_valid_i = 1'b1;
        bus.chk_allow_i = 1'b1;
        settle();
        check("t1_rsp_early", 64'(bus.rsp_valid_o), 64'd0);
        tick();
        bus.chk_valid_i = 1'b0;
        bus.chk_allow_i = 1'b0;
        settle();
        check("t1_rsp_latency", 64'(bus.rsp_valid_o), 64'b0100);
        check("t1_rsp_allow", 64'(bus.rsp_allow_o), 64'd1);
        tick();
        check("t1_rsp_one_cycle", 64'(bus.rsp_valid_o), 64'd0);

        // Engine verdict while IDLE must be ignored.
        bus.chk_valid_i = 1'b1;
        bus.chk_allow_i = 1'b1;
        tick();
        tick();
        bus.chk_valid_i = 1'b0;
        bus.chk_allow_i = 1'b0;
        check("idle_verdict_ignored", 64'(bus.busy_o), 64'd0);

        // Fresh reset, all four requesting, engine denies: 0,1,2,3,0.
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, 64'h1000 * i, 8'(8'h10 + i), ACC_WRITE);
        for (int k = 0; k < 5; k++) begin
            settle();
            check("t2_grant", 64'(bus.req_ready_o), 64'(4'b0001 << (k % 4)));
            push(k % 4, 1'b0, 1'b0);
            tick();
            settle();
            check("t2_chk_sid", 64'(bus.chk_sid_o), 64'(8'h10 + (k % 4)));
            tick();
            bus.chk_valid_i = 1'b1;
            tick();
            bus.chk_valid_i = 1'b0;
            tick();
        end
        clear_inputs();
        bus.chk_ready_i = 1'b1;

        // ISSUE stall: chk_ready_i low 5 cycles (rr_ptr is 1 here).
        bus.chk_ready_i = 1'b0;
        set_req(1, 64'h1230, 8'h21, ACC_WRITE);
        settle();
        check("t3_grant", 64'(bus.req_ready_o), 64'b0010);
        push(1, 1'b1, 1'b0);
        tick();
        bus.req_valid_i[1] = 1'b0;
        set_req(3, 64'h3000, 8'h33, ACC_READ);
        for (int s = 0; s < 5; s++) begin
            bus.chk_valid_i = 1'b1;
            settle();
            check("t3_stall_chk_en", 64'(bus.chk_en_o), 64'd0);
            check("t3_stall_ready", 64'(bus.req_ready_o), 64'd0);
            tick();
        end
        bus.chk_valid_i = 1'b0;
        bus.chk_ready_i = 1'b1;
        settle();
        check("t3_chk_en", 64'(bus.chk_en_o), 64'd1);
        check("t3_chk_addr", bus.chk_addr_o, 64'h1230);
        check("t3_chk_access", 64'(bus.chk_access_o), 64'(ACC_WRITE));
        tick();
        check("t3_chk_en_single", 64'(bus.chk_en_o), 64'd0);
        bus.chk_valid_i = 1'b1;
        bus.chk_allow_i = 1'b1;
        tick();
        bus.chk_valid_i = 1'b0;
        bus.chk_allow_i = 1'b0;
        settle();
        check("t3_rsp", 64'(bus.rsp_valid_o), 64'b0010);
        tick();
        settle();
        check("t3_next_grant", 64'(bus.req_ready_o), 64'b1000);
        push(3, 1'b0, 1'b0);
        tick();
        bus.req_valid_i = '0;
        tick();
        bus.chk_valid_i = 1'b1;
        tick();
        bus.chk_valid_i = 1'b0;
        tick();

        // rr_ptr wrapped to 0: ports 1 and 2 compete, 1 wins.
        set_req(1, 64'h1111, 8'h41, ACC_EXEC);
        set_req(2, 64'h2222, 8'h42, ACC_EXEC);
        settle();
        check("t4_wrap_grant", 64'(bus.req_ready_o), 64'b0010);
        push(1, 1'b1, 1'b0);
        tick();
        bus.req_valid_i = '0;
        tick();
        bus.chk_valid_i = 1'b1;
        bus.chk_allow_i = 1'b1;
        tick();
        bus.chk_valid_i = 1'b0;
        bus.chk_allow_i = 1'b0;
        tick();

        // Reset during WAIT (rr_ptr is 2 before reset).
        set_req(2, 64'h2000, 8'h52, ACC_READ);
        settle();
        check("t5_grant", 64'(bus.req_ready_o), 64'b0100);
        tick();
        bus.req_valid_i = '0;
        tick();
        tick();
        tick();
        set_req(1, 64'h0100, 8'h61, ACC_READ);
        set_req(3, 64'h0300, 8'h63, ACC_READ);
        rst_n = 1'b0;
        bus.chk_valid_i = 1'b1;
        bus.chk_allow_i = 1'b1;
        settle();
        check("t5_rst_busy", 64'(bus.busy_o), 64'd0);
        check("t5_rst_ready", 64'(bus.req_ready_o), 64'd0);
        check("t5_rst_rsp", 64'(bus.rsp_valid_o), 64'd0);
        check("t5_rst_allow", 64'(bus.rsp_allow_o), 64'd0);
        check("t5_rst_chk_en", 64'(bus.chk_en_o), 64'd0);
        tick();
        bus.chk_valid_i = 1'b0;
        bus.chk_allow_i = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        check("t5_post_rst_grant", 64'(bus.req_ready_o), 64'b0010);
        push(1, 1'b1, 1'b0);
        tick();
        bus.req_valid_i = '0;
        tick();
        bus.chk_valid_i = 1'b1;
        bus.chk_allow_i = 1'b1;
        tick();
        bus.chk_valid_i = 1'b0;
        bus.chk_allow_i = 1'b0;
        tick();

        // Watchdog behaviour (rr_ptr is 2 here).
        set_req(2, 64'h7000, 8'h72, ACC_WRITE);
        settle();
        check("t6_grant", 64'(bus.req_ready_o), 64'b0100);
`ifdef RV_IOPMP_ARB_TIMEOUT_EN
        push(2, 1'b0, 1'b1);
        tick();
        bus.req_valid_i = '0;
        tick();
        for (int k = 1; k <= 8; k++) begin
            settle();
            check("t6_rsp_early", 64'(bus.rsp_valid_o), 64'd0);
            tick();
        end
        check("t6_timeout_pulse", 64'(bus.timeout_o), 64'd1);
        check("t6_timeout_allow", 64'(bus.rsp_allow_o), 64'd0);
        tick();
        check("t6_timeout_one_cycle", 64'(bus.timeout_o), 64'd0);
        set_req(3, 64'h7300, 8'h73, ACC_READ);
        push(3, 1'b1, 1'b0);
        tick();
        bus.req_valid_i = '0;
        tick();
        repeat (7) tick();
        bus.chk_valid_i = 1'b1;
        bus.chk_allow_i = 1'b1;
        tick();
        bus.chk_valid_i = 1'b0;
        bus.chk_allow_i = 1'b0;
        settle();
        check("t6_expiry_engine_wins", 64'(bus.timeout_o), 64'd0);
        check("t6_expiry_allow", 64'(bus.rsp_allow_o), 64'd1);
        tick();
`else
        push(2, 1'b1, 1'b0);
        tick();
        bus.req_valid_i = '0;
        tick();
        repeat (100) tick();
        check("t6_still_waiting", 64'(bus.busy_o), 64'd1);
        check("t6_no_rsp", 64'(bus.rsp_valid_o), 64'd0);
        check("t6_no_timeout", 64'(bus.timeout_o), 64'd0);
        bus.chk_valid_i = 1'b1;
        bus.chk_allow_i = 1'b1;
        tick();
        bus.chk_valid_i = 1'b0;
        bus.chk_allow_i = 1'b0;
        tick();
`endif
        tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
